led4_pipe_rot: RTL and testbench



---
 rtl/led4_pipe_rot.sv | 86 ++++++++
 tb/tb_led4_pipe_rot.sv | 88 ++++++++
 2 files changed

// File: rtl/led4_pipe_rot.sv
// led4_pipe_rot: four-LED running light.
// A 4-bit pattern advances one step every STEP_CYCLES clocks. It either rotates
// circularly (MODE=0) or bounces between the end LEDs (MODE=1). Each output is
// optionally inverted for active-low LEDs.
// The diode outputs come straight from a register, so the pins never glitch
// and no combinational path runs from reset to a pin.
module led4_pipe_rot #(
    parameter int unsigned STEP_CYCLES  = 1,
    parameter logic [3:0]  INIT_PATTERN = 4'b0001,
    parameter logic        DIR          = 1'b0,
    parameter logic        MODE         = 1'b0,
    parameter logic        ACTIVE_LOW   = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] diode
);

    localparam int unsigned     CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(STEP_CYCLES - 1);
    localparam logic [3:0]      MASK = {4{ACTIVE_LOW}};

    // A zero step length has no meaning, so stop the build.
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("led4_pipe_rot: STEP_CYCLES must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic [3:0]    pat;
    logic          dir;
    logic          tick;
    logic [3:0]    pat_nxt;
    logic          dir_nxt;

    assign tick = (cnt == LAST);

    // Next pattern and direction if a step happens on this edge.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (MODE == 1'b0) begin
            // A plain rotate keeps the pattern's shape, whether or not it is one-hot.
            if (!dir) pat_nxt = {pat[2:0], pat[3]};
            else      pat_nxt = {pat[0], pat[3:1]};
        end else if (!$onehot(pat)) begin
            // Bounce needs exactly one lit LED. Otherwise restart from the LSB end.
            pat_nxt = 4'b0001;
            dir_nxt = 1'b0;
        end else if (!dir) begin
            if (pat == 4'b1000) begin
                pat_nxt = 4'b0100;
                dir_nxt = 1'b1;
            end else begin
                pat_nxt = pat << 1;
            end
        end else begin
            if (pat == 4'b0001) begin
                pat_nxt = 4'b0010;
                dir_nxt = 1'b0;
            end else begin
                pat_nxt = pat >> 1;
            end
        end
    end

    // Divider, pattern, direction and the registered LED drive.
    // Reset has priority over a step on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            pat   <= INIT_PATTERN;
            dir   <= DIR;
            diode <= INIT_PATTERN ^ MASK;
        end else begin
            if (tick) begin
                cnt   <= '0;
                pat   <= pat_nxt;
                dir   <= dir_nxt;
                diode <= pat_nxt ^ MASK;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led4_pipe_rot.sv
// tb_led4_pipe_rot: directed vectors for several configurations of the LED driver.
// Hand-computed expected diode values sit in a table: index 0 is the value
// after reset and index k is the value after rising edge k.
module tb_led4_pipe_rot;

    localparam int N_DUT  = 7;
    localparam int N_EDGE = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] obs [N_DUT];
    logic [3:0] exp_tab [N_DUT][N_EDGE+1];
    string      names [N_DUT];

    int n_vec = 0;
    int n_bad = 0;

    // 40 ns clock.
    always #20 clock = ~clock;

    led4_pipe_rot u_def (.clock(clock), .reset(reset), .diode(obs[0]));
    led4_pipe_rot #(.STEP_CYCLES(3)) u_sc3 (.clock(clock), .reset(reset), .diode(obs[1]));
    led4_pipe_rot #(.DIR(1'b1)) u_dir1 (.clock(clock), .reset(reset), .diode(obs[2]));
    led4_pipe_rot #(.MODE(1'b1)) u_bnc (.clock(clock), .reset(reset), .diode(obs[3]));
    led4_pipe_rot #(.MODE(1'b1), .INIT_PATTERN(4'b0011)) u_bad (.clock(clock), .reset(reset), .diode(obs[4]));
    led4_pipe_rot #(.ACTIVE_LOW(1'b1)) u_al (.clock(clock), .reset(reset), .diode(obs[5]));
    led4_pipe_rot #(.INIT_PATTERN(4'b0011)) u_rot3 (.clock(clock), .reset(reset), .diode(obs[6]));

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    initial begin
        names[0] = "def";  names[1] = "sc3"; names[2] = "dir1"; names[3] = "bounce";
        names[4] = "bad_init"; names[5] = "active_low"; names[6] = "rot0011";
        exp_tab[0] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_tab[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
        exp_tab[2] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_tab[3] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        exp_tab[4] = '{4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        exp_tab[5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_tab[6] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};

        // Hold reset over one rising edge, then sample on the falling edge.
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < N_DUT; d++)
            check($sformatf("%s_reset", names[d]), obs[d], exp_tab[d][0]);
        reset = 1'b0;

        // Free run: compare every configuration after each edge.
        for (int e = 1; e <= N_EDGE; e++) begin
            @(negedge clock);
            for (int d = 0; d < N_DUT; d++)
                check($sformatf("%s_edge%0d", names[d], e), obs[d], exp_tab[d][e]);
        end

        // Mid-run reset: advance the default instance to 1000 first.
        // After edge 8 it shows 0001. Edges 9, 10 and 11 give 0010, 0100 and 1000.
        repeat (3) @(negedge clock);
        check("def_pre_reset", obs[0], 4'b1000);
        reset = 1'b1;
        @(negedge clock);
        check("def_midreset", obs[0], 4'b0001);
        check("sc3_midreset", obs[1], 4'b0001);
        check("bad_midreset", obs[4], 4'b0011);
        reset = 1'b0;
        @(negedge clock);
        check("def_after_midreset", obs[0], 4'b0010);
        check("sc3_after_midreset", obs[1], 4'b0001);
        check("al_after_midreset", obs[5], 4'b1101);
        // The step-3 divider restarts from zero, so the first step lands on the third edge.
        @(negedge clock);
        check("sc3_midreset_e2", obs[1], 4'b0001);
        @(negedge clock);
        check("sc3_midreset_e3", obs[1], 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
